pistormx_wrbuf: RTL

Posted-write queue between the Pi register interface and the 68K bus cycle sequencer in the Pistorm'X CPLD. Captures each Pi transaction (address, size, direction, data) into an in-order FIFO so writes complete on the Pi side without waiting for the slow 68K/E-clock bus cycle. The queue presents one entry at a time to the bus sequencer. Reads are ordered behind all queued writes, and the Pi stays busy until read data returns.

---
 rtl/pistormx_wrbuf.sv | 136 +++++++++++++
 1 files changed

// File: rtl/pistormx_wrbuf.sv
// pistormx_wrbuf: in-order posted-write queue between the Pi register interface and the 68K bus sequencer.
// Define PISTORMX_WRBUF_EN to post through DEPTH entries; undefined gives a single unbuffered entry.
module pistormx_wrbuf #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                    M68K_CLK,
    input  logic                    RST,
    input  logic                    PI_REQ,
    input  logic [22:0]             PI_ADDR,
    input  logic                    PI_A0,
    input  logic                    PI_SZ,
    input  logic                    PI_RW,
    input  logic [15:0]             PI_WDATA,
    output logic                    PI_BUSY,
    output logic [15:0]             PI_RDATA,
    output logic                    BUS_REQ,
    output logic [22:0]             BUS_ADDR,
    output logic                    BUS_A0,
    output logic                    BUS_SZ,
    output logic                    BUS_RW,
    output logic [15:0]             BUS_WDATA,
    input  logic                    BUS_ACK,
    input  logic                    BUS_DONE,
    input  logic [15:0]             BUS_RDATA,
    output logic [$clog2(DEPTH):0]  FIFO_LEVEL,
    output logic                    OVF
);

`ifdef PISTORMX_WRBUF_EN
    localparam int unsigned SLOTS = DEPTH;
`else
    localparam int unsigned SLOTS = 1;
`endif
    localparam int unsigned LW = $clog2(DEPTH) + 1;
    localparam int unsigned PW = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    localparam int unsigned EW = 42;

    typedef enum logic [1:0] {IDLE, OFFER, FLIGHT} state_t;

    state_t          state, state_next;
    logic [EW-1:0]   mem [SLOTS];
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [LW-1:0]   level, level_next;
    logic            rd_pending, rd_pending_next;
    logic            push, pop, load;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(SLOTS - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        push = PI_REQ && !PI_BUSY;
        pop  = (state == FLIGHT) && BUS_DONE;
        load = (state == IDLE) && (level != '0);

        level_next = level;
        if (push && !pop)
            level_next = level + 1'b1;
        else if (pop && !push)
            level_next = level - 1'b1;

        rd_pending_next = rd_pending;
        if (push && PI_RW)
            rd_pending_next = 1'b1;
        else if (pop && BUS_RW)
            rd_pending_next = 1'b0;
    end

    always_ff @(posedge M68K_CLK) begin
        if (RST)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Every completed cycle returns through IDLE: this yields the idle gap between
    // offers and reloads the head from storage that is already committed.
    always_comb begin
        state_next = state;
        BUS_REQ    = 1'b0;
        case (state)
            IDLE:    if (level != '0) state_next = OFFER;
            OFFER: begin
                BUS_REQ = 1'b1;
                if (BUS_ACK) state_next = FLIGHT;
            end
            FLIGHT:  if (BUS_DONE) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge M68K_CLK) begin
        if (RST) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            rd_pending <= 1'b0;
            PI_BUSY    <= 1'b0;
            PI_RDATA   <= '0;
            OVF        <= 1'b0;
        end else begin
            level      <= level_next;
            rd_pending <= rd_pending_next;
            PI_BUSY    <= (level_next == LW'(SLOTS)) || rd_pending_next;
            if (PI_REQ && PI_BUSY)
                OVF <= 1'b1;
            if (push)
                wr_ptr <= ptr_inc(wr_ptr);
            if (pop)
                rd_ptr <= ptr_inc(rd_ptr);
            if (pop && BUS_RW)
                PI_RDATA <= BUS_RDATA;
        end
    end

    always_ff @(posedge M68K_CLK) begin
        if (push)
            mem[wr_ptr] <= {PI_ADDR, PI_A0, PI_SZ, PI_RW, PI_WDATA};
    end

    // Head registers hold steady from OFFER through FLIGHT for the address/data drivers.
    always_ff @(posedge M68K_CLK) begin
        if (RST) begin
            BUS_ADDR  <= '0;
            BUS_A0    <= 1'b0;
            BUS_SZ    <= 1'b0;
            BUS_RW    <= 1'b1;
            BUS_WDATA <= '0;
        end else if (load) begin
            {BUS_ADDR, BUS_A0, BUS_SZ, BUS_RW, BUS_WDATA} <= mem[rd_ptr];
        end
    end

    assign FIFO_LEVEL = level;

endmodule
